// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx
// Purpose  : I2S master receiver. Generates SCK and WS from the system clock,
//            captures left/right samples from SD (MSB first, one-bit delay
//            after each WS edge), discards the first frames after enable and
//            presents stereo pairs through a valid/ready output register with
//            a sticky overrun flag.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-low reset
//            en           - receiver enable
//            sd           - serial data from the transmitter
//            sck, ws      - generated bit clock / word select (1 = right)
//            left_data    - left sample, two's complement
//            right_data   - right sample, two's complement
//            out_valid    - a stereo pair is held on left_data/right_data
//            out_ready    - consumer accepts the held pair
//            overrun      - sticky, a completed pair was dropped
//            clr_overrun  - synchronous clear of overrun
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx #(
  parameter int HALF_DIV       = 2,
  parameter int SLOT_BITS      = 32,
  parameter int DATA_BITS      = 24,
  parameter int DISCARD_FRAMES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sd,
  output logic                 sck,
  output logic                 ws,
  output logic [DATA_BITS-1:0] left_data,
  output logic [DATA_BITS-1:0] right_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
  localparam int FRM_W = (DISCARD_FRAMES > 0) ? $clog2(DISCARD_FRAMES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_N   = BIT_W'(DATA_BITS);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((DISCARD_FRAMES > 0) ? DISCARD_FRAMES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [FRM_W-1:0]     frame_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] pend_left;
  logic                 pair_done;

  logic                 active;
  logic                 div_wrap;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 frame_wrap;
  logic                 in_right;
  logic [BIT_W-1:0]     slot_pos;
  logic [BIT_W-1:0]     bit_next;
  logic                 capture;
  logic                 last_bit;
  logic [DATA_BITS:0]   shift_ext;
  logic [DATA_BITS-1:0] shift_next;
  logic                 discard_done;
  logic                 accept;

  // Counters only run while enabled outside IDLE; the edge that leaves IDLE
  // leaves them at zero so the first SCK rise lands HALF_DIV cycles later.
  assign active       = en && (state != IDLE);
  assign div_wrap     = (div_cnt == DIV_LAST);
  assign sck_rise     = active && div_wrap && !sck;
  assign sck_fall     = active && div_wrap && sck;
  assign frame_wrap   = sck_fall && (bit_cnt == BIT_LAST);
  assign bit_next     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign in_right     = (bit_cnt >= SLOT_N);
  assign slot_pos     = in_right ? (bit_cnt - SLOT_N) : bit_cnt;
  // Position 0 is the I2S one-bit delay; positions past DATA_BITS are padding.
  assign capture      = sck_rise && (slot_pos != '0) && (slot_pos <= DATA_N);
  assign last_bit     = sck_rise && (slot_pos == DATA_N);
  assign shift_ext    = {shift, sd};
  assign shift_next   = shift_ext[DATA_BITS-1:0];
  assign discard_done = (DISCARD_FRAMES == 0) || (frame_wrap && (frame_cnt == FRM_LAST));
  assign accept       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SYNC;
      SYNC:    if (discard_done) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (!en) state_next = IDLE;
  end

  // Bit-clock generation and serial capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      sck       <= 1'b0;
      bit_cnt   <= '0;
      ws        <= 1'b0;
      frame_cnt <= '0;
      shift     <= '0;
      pend_left <= '0;
      pair_done <= 1'b0;
    end else if (!active) begin
      div_cnt   <= '0;
      sck       <= 1'b0;
      bit_cnt   <= '0;
      ws        <= 1'b0;
      frame_cnt <= '0;
      shift     <= '0;
      pend_left <= '0;
      pair_done <= 1'b0;
    end else begin
      pair_done <= 1'b0;
      if (div_wrap) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (sck_fall) begin
        bit_cnt <= bit_next;
        ws      <= (bit_next >= SLOT_N);
      end
      if (state == SYNC && frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (capture) begin
        shift <= shift_next;
      end
      if (last_bit && !in_right) begin
        pend_left <= shift_next;
      end
      // Pairs finished during SYNC are deliberately never flagged.
      if (last_bit && in_right && (state == RUN)) begin
        pair_done <= 1'b1;
      end
    end
  end

  // Output register: pair_done is one cycle after the final right capture,
  // so shift still holds the complete right sample here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (pair_done && (!out_valid || accept)) begin
        left_data  <= pend_left;
        right_data <= shift;
        out_valid  <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      // A drop sets the flag even when a clear is requested in the same cycle.
      if (pair_done && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx
// Purpose  : Self-checking bench for i2s_rx with default parameters. An I2S
//            transmitter model follows SCK/WS and sends per-frame words; the
//            expected output stream is the list of sent frames after the
//            first (discarded) one, with timing derived from the SCK/frame
//            period arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sd;
  logic        sck;
  logic        ws;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        clr_overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  i2s_rx #(
    .HALF_DIV(2),
    .SLOT_BITS(32),
    .DATA_BITS(24),
    .DISCARD_FRAMES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sd(sd),
    .sck(sck),
    .ws(ws),
    .left_data(left_data),
    .right_data(right_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- transmitter model ----------------
  bit          golden_mode = 1'b0;
  logic [23:0] tx_left, tx_right;
  logic [47:0] tx_q[$];
  int          tx_idx = 0;
  bit          tx_started = 1'b0;
  logic        prev_sck = 1'b0;
  logic        prev_ws = 1'b0;

  task automatic new_frame();
    if (golden_mode) begin
      tx_left  = 24'hA5A5A5;
      tx_right = 24'h5A5A5A;
    end else begin
      tx_left  = 24'($urandom);
      tx_right = 24'($urandom);
    end
    tx_q.push_back({tx_left, tx_right});
  endtask

  // Bits are launched on SCK falling edges; index 0 after a WS change is the
  // one-bit delay, indices 1..24 carry the word MSB first.
  always @(negedge clk) begin
    if (!en) begin
      tx_idx     = 0;
      tx_started = 1'b0;
      tx_q.delete();
    end else if (!tx_started) begin
      tx_started = 1'b1;
      new_frame();
    end else if (prev_sck && !sck) begin
      if (ws != prev_ws) begin
        tx_idx = 0;
        if (!ws) new_frame();
      end else begin
        tx_idx++;
      end
    end
    prev_sck = sck;
    prev_ws  = ws;
    if (tx_idx >= 1 && tx_idx <= 24)
      sd = ws ? tx_right[24-tx_idx] : tx_left[24-tx_idx];
    else
      sd = 1'($urandom);
  end

  // ---------------- helpers ----------------
  task automatic wait_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_run(output int entry);
    @(negedge clk);
    en = 1'b1;
    entry = cyc + 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; out_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL reset_sck: got %b expected 0", sck); end
    checks++; if (ws !== 1'b0) begin failures++; $display("FAIL reset_ws: got %b expected 0", ws); end
    checks++; if (left_data !== 24'h0) begin failures++; $display("FAIL reset_left: got %h expected 000000", left_data); end
    checks++; if (right_data !== 24'h0) begin failures++; $display("FAIL reset_right: got %h expected 000000", right_data); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    en = 1'b0; rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL idle_sck_without_en: got %b expected 0", sck); end
  endtask

  task automatic test_clocking();
    int e, last_rise, n_rise, bad_gap, bad_ws;
    logic ps, pw;
    int ws_rise[$];
    do_reset();
    golden_mode = 1'b0;
    start_run(e);
    wait_edge(e + 1);
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL first_rise_early: sck=%b at entry+1 expected 0", sck); end
    wait_edge(e + 2);
    checks++; if (sck !== 1'b1) begin failures++; $display("FAIL first_rise: sck=%b at entry+2 expected 1", sck); end
    last_rise = e + 2; n_rise = 0; bad_gap = 0; bad_ws = 0;
    ps = sck; pw = ws;
    for (int c = e + 3; c <= e + 700; c++) begin
      wait_edge(c);
      if (sck && !ps) begin
        if (c - last_rise != 4) bad_gap++;
        last_rise = c;
        n_rise++;
      end
      if (ws !== pw) begin
        if (!(ps && !sck)) bad_ws++;
        if (ws) ws_rise.push_back(c - e);
      end
      ps = sck; pw = ws;
    end
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL sck_period: %0d gaps differ, expected 0 (period 4)", bad_gap); end
    checks++; if (n_rise != 174) begin failures++; $display("FAIL sck_rise_count: got %0d expected 174", n_rise); end
    checks++; if (bad_ws != 0) begin failures++; $display("FAIL ws_on_sck_fall: %0d ws edges off sck fall, expected 0", bad_ws); end
    checks++; if (ws_rise.size() != 3) begin failures++; $display("FAIL ws_rise_count: got %0d expected 3", ws_rise.size()); end
    for (int i = 0; i < ws_rise.size(); i++) begin
      checks++;
      if (ws_rise[i] != 128 + 256 * i) begin
        failures++; $display("FAIL ws_rise_time[%0d]: got entry+%0d expected entry+%0d", i, ws_rise[i], 128 + 256 * i);
      end
    end
  endtask

  task automatic test_capture(input bit golden);
    int e, np;
    logic [47:0] exp;
    do_reset();
    golden_mode = golden;
    out_ready = 1'b1;
    start_run(e);
    np = 0;
    for (int c = e + 1; c <= e + 483 + 256 * 4 + 10; c++) begin
      wait_edge(c);
      if (out_valid) begin
        np++;
        if (golden) exp = {24'hA5A5A5, 24'h5A5A5A};
        else if (np < tx_q.size()) exp = tx_q[np];
        else exp = 'x;
        checks++;
        if (c - e != 483 + 256 * (np - 1)) begin
          failures++; $display("FAIL capture_time(golden=%0d) pair %0d: at entry+%0d expected entry+%0d", golden, np, c - e, 483 + 256 * (np - 1));
        end
        checks++;
        if ({left_data, right_data} !== exp) begin
          failures++; $display("FAIL capture_data(golden=%0d) pair %0d: got %h/%h expected %h/%h", golden, np, left_data, right_data, exp[47:24], exp[23:0]);
        end
      end
    end
    checks++; if (np != 5) begin failures++; $display("FAIL capture_count(golden=%0d): got %0d pairs expected 5", golden, np); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int e;
    logic [47:0] f1;
    do_reset();
    golden_mode = 1'b0;
    start_run(e);
    wait_edge(e + 483);
    f1 = tx_q[1];
    checks++; if (out_valid !== 1'b1 || {left_data, right_data} !== f1) begin
      failures++; $display("FAIL bp_first_pair: valid=%b data=%h/%h expected 1 %h/%h", out_valid, left_data, right_data, f1[47:24], f1[23:0]);
    end
    wait_edge(e + 738);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_overrun_early: got %b expected 0", overrun); end
    wait_edge(e + 739);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_set: got %b expected 1", overrun); end
    checks++; if (out_valid !== 1'b1 || {left_data, right_data} !== f1) begin
      failures++; $display("FAIL bp_held: valid=%b data=%h/%h expected 1 %h/%h", out_valid, left_data, right_data, f1[47:24], f1[23:0]);
    end
    clr_overrun = 1'b1;
    wait_edge(e + 740);
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_overrun_clear: got %b expected 0", overrun); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_after_clear: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    wait_edge(e + 741);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_accept: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    int e;
    logic [47:0] f1, f2;
    do_reset();
    golden_mode = 1'b0;
    start_run(e);
    wait_edge(e + 483);
    f1 = tx_q[1];
    checks++; if (out_valid !== 1'b1 || {left_data, right_data} !== f1) begin
      failures++; $display("FAIL sim_first_pair: valid=%b data=%h/%h expected 1 %h/%h", out_valid, left_data, right_data, f1[47:24], f1[23:0]);
    end
    wait_edge(e + 738);
    f2 = tx_q[2];
    out_ready = 1'b1;
    wait_edge(e + 739);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sim_valid_stays: got %b expected 1", out_valid); end
    checks++; if ({left_data, right_data} !== f2) begin
      failures++; $display("FAIL sim_new_pair: got %h/%h expected %h/%h", left_data, right_data, f2[47:24], f2[23:0]);
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL sim_overrun: got %b expected 0", overrun); end
    wait_edge(e + 745);
    checks++; if (out_valid !== 1'b1 || {left_data, right_data} !== f2) begin
      failures++; $display("FAIL sim_hold: valid=%b data=%h/%h expected 1 %h/%h", out_valid, left_data, right_data, f2[47:24], f2[23:0]);
    end
  endtask

  task automatic test_disable();
    int e, e2, bad, np;
    logic [47:0] f1, exp;
    do_reset();
    golden_mode = 1'b0;
    start_run(e);
    wait_edge(e + 483);
    f1 = tx_q[1];
    wait_edge(e + 673);
    checks++; if (ws !== 1'b1) begin failures++; $display("FAIL dis_ws_before: got %b expected 1 at bit 40", ws); end
    en = 1'b0;
    wait_edge(e + 674);
    checks++; if (sck !== 1'b0) begin failures++; $display("FAIL dis_sck: got %b expected 0", sck); end
    checks++; if (ws !== 1'b0) begin failures++; $display("FAIL dis_ws: got %b expected 0", ws); end
    bad = 0;
    for (int c = e + 675; c <= e + 1000; c++) begin
      wait_edge(c);
      if (out_valid !== 1'b1 || {left_data, right_data} !== f1 || overrun !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL dis_pair_held: %0d cycles changed, expected 0", bad); end
    out_ready = 1'b1;
    wait_edge(cyc + 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dis_accept: valid=%b expected 0", out_valid); end
    start_run(e2);
    np = 0;
    for (int c = e2 + 1; c <= e2 + 493; c++) begin
      wait_edge(c);
      if (out_valid) begin
        np++;
        exp = (tx_q.size() > 1) ? tx_q[1] : 'x;
        checks++;
        if (c - e2 != 483 || {left_data, right_data} !== exp) begin
          failures++; $display("FAIL reen_pair: at entry+%0d data %h/%h expected entry+483 %h/%h", c - e2, left_data, right_data, exp[47:24], exp[23:0]);
        end
      end
    end
    checks++; if (np != 1) begin failures++; $display("FAIL reen_count: got %0d pairs expected 1", np); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int e, n;
    do_reset();
    golden_mode = 1'b0;
    start_run(e);
    n = $urandom_range(500, 1000);
    wait_edge(e + n);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid); end
    #1 rst = 1'b0;
    #1;
    checks++; if (sck !== 1'b0 || ws !== 1'b0) begin failures++; $display("FAIL ar_clocks: sck=%b ws=%b expected 0 0", sck, ws); end
    checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin failures++; $display("FAIL ar_data: got %h/%h expected 0/0", left_data, right_data); end
    checks++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL ar_flags: valid=%b overrun=%b expected 0 0", out_valid, overrun); end
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clocking();
    test_capture(1'b1);
    test_capture(1'b0);
    test_backpressure();
    test_simultaneous();
    test_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
